// File: rtl/inst_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : inst_buffer
//  Purpose  : Circular instruction buffer between predecode and decode.
//             Accepts whole predecode blocks and issues FETCH_WIDTH-wide
//             bundles.
//  Revision : 1.0  initial release
// ============================================================================
module inst_buffer #(
    parameter int BLOCK_INST_SIZE = 8,
    parameter int FETCH_WIDTH     = 4,
    parameter int DEPTH           = 16,
    parameter int FSQ_WIDTH       = 5
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [BLOCK_INST_SIZE-1:0]                 en,
    input  logic [$clog2(BLOCK_INST_SIZE)-1:0]         num,
    input  logic [BLOCK_INST_SIZE-1:0][31:0]           inst,
    input  logic [FSQ_WIDTH-1:0]                       fsqIdx,
    input  logic                                       flush,
    input  logic                                       stall,
    output logic                                       full,
    output logic [FETCH_WIDTH-1:0]                     out_en,
    output logic [FETCH_WIDTH-1:0][31:0]               out_inst,
    output logic [FETCH_WIDTH-1:0][FSQ_WIDTH-1:0]      out_fsqIdx
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NUM_W = $clog2(BLOCK_INST_SIZE);

    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_BLOCK = CNT_W'(BLOCK_INST_SIZE);
    localparam logic [CNT_W-1:0] C_FETCH = CNT_W'(FETCH_WIDTH);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    generate
        if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < BLOCK_INST_SIZE + FETCH_WIDTH) begin : g_bad_depth
            $error("inst_buffer: DEPTH must be a power of two >= BLOCK_INST_SIZE + FETCH_WIDTH");
        end
    endgenerate

    logic [31:0]          inst_mem_q [DEPTH];
    logic [FSQ_WIDTH-1:0] fsq_mem_q  [DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] head_d;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] tail_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic             wr_req;
    logic             wr_accept;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;

    // Full only looks at registered occupancy so the frontend sees no input path.
    assign full      = (C_DEPTH - count_q) < C_BLOCK;
    assign wr_req    = |en;
    assign wr_accept = wr_req && !full && !flush;
    assign wr_cnt    = wr_accept ? (CNT_W'(num) + C_ONE) : '0;
    assign rd_cnt    = (stall || flush) ? '0 : ((count_q < C_FETCH) ? count_q : C_FETCH);

    always_comb begin
        head_d  = head_q + PTR_W'(rd_cnt);
        tail_d  = tail_q + PTR_W'(wr_cnt);
        count_d = count_q + wr_cnt - rd_cnt;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload is never cleared; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
                if (NUM_W'(i) <= num) begin
                    inst_mem_q[tail_q + PTR_W'(i)] <= inst[i];
                    fsq_mem_q[tail_q + PTR_W'(i)]  <= fsqIdx;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_read
            assign out_en[gi]     = (count_q > CNT_W'(gi)) && !flush && !rst;
            assign out_inst[gi]   = inst_mem_q[head_q + PTR_W'(gi)];
            assign out_fsqIdx[gi] = fsq_mem_q[head_q + PTR_W'(gi)];
        end
    endgenerate

    a_no_write_when_full : assert property (@(posedge clk) disable iff (rst)
        !(wr_req && full && !flush))
        else $warning("inst_buffer: block dropped, written while buffer full");

    a_count_range : assert property (@(posedge clk) disable iff (rst)
        (count_q <= C_DEPTH) &&
        (({1'b0, count_q} + {1'b0, wr_cnt}) >= {1'b0, rd_cnt}) &&
        (({1'b0, count_q} + {1'b0, wr_cnt}) <= ({1'b0, C_DEPTH} + {1'b0, rd_cnt})))
        else $error("inst_buffer: occupancy out of range");

endmodule
`default_nettype wire

// File: tb/tb_inst_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_inst_buffer
//  Purpose  : Self-checking bench for inst_buffer using a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_buffer;

    localparam int BIS   = 8;
    localparam int FW    = 4;
    localparam int DEPTH = 16;
    localparam int FSQ_W = 5;
    localparam int NUM_W = 3;

    logic                      clk    = 1'b0;
    logic                      rst    = 1'b1;
    logic [BIS-1:0]            en     = '0;
    logic [NUM_W-1:0]          num    = '0;
    logic [BIS-1:0][31:0]      inst   = '0;
    logic [FSQ_W-1:0]          fsqIdx = '0;
    logic                      flush  = 1'b0;
    logic                      stall  = 1'b0;
    logic                      full;
    logic [FW-1:0]             out_en;
    logic [FW-1:0][31:0]       out_inst;
    logic [FW-1:0][FSQ_W-1:0]  out_fsqIdx;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]      m_inst[$];
    logic [FSQ_W-1:0] m_fsq[$];

    typedef struct packed {
        logic [3:0]       w;
        logic [FSQ_W-1:0] f;
        logic             fl;
        logic             st;
        logic             rs;
    } row_t;

    inst_buffer #(
        .BLOCK_INST_SIZE(BIS),
        .FETCH_WIDTH(FW),
        .DEPTH(DEPTH),
        .FSQ_WIDTH(FSQ_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .num(num),
        .inst(inst),
        .fsqIdx(fsqIdx),
        .flush(flush),
        .stall(stall),
        .full(full),
        .out_en(out_en),
        .out_inst(out_inst),
        .out_fsqIdx(out_fsqIdx)
    );

    always #5 clk = ~clk;

    function automatic logic model_full();
        return (DEPTH - m_inst.size()) < BIS;
    endfunction

    function automatic logic [FW-1:0] model_en();
        logic [FW-1:0] m;
        m = '0;
        if (!flush && !rst)
            for (int i = 0; i < FW; i++)
                if (i < m_inst.size()) m[i] = 1'b1;
        return m;
    endfunction

    task automatic drive(input row_t r);
        @(negedge clk);
        en     = (r.w == 0) ? '0 : BIS'((1 << r.w) - 1);
        num    = (r.w == 0) ? NUM_W'($urandom) : NUM_W'(r.w - 1);
        for (int i = 0; i < BIS; i++) inst[i] = $urandom;
        fsqIdx = r.f;
        flush  = r.fl;
        stall  = r.st;
        rst    = r.rs;
    endtask

    // Advance the reference model across one rising edge.
    task automatic tick();
        bit acc;
        int r;
        acc = (en != '0) && !model_full() && !flush && !rst;
        @(posedge clk);
        if (rst || flush) begin
            m_inst.delete();
            m_fsq.delete();
        end else begin
            r = stall ? 0 : ((m_inst.size() < FW) ? m_inst.size() : FW);
            repeat (r) begin
                void'(m_inst.pop_front());
                void'(m_fsq.pop_front());
            end
            if (acc)
                for (int i = 0; i <= int'(num); i++) begin
                    m_inst.push_back(inst[i]);
                    m_fsq.push_back(fsqIdx);
                end
        end
    endtask

    task automatic test_reset();
        row_t r;
        r = '{w: 4'd8, f: 5'd1, fl: 1'b0, st: 1'b0, rs: 1'b1};
        drive(r);
        tick();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                r.rs = 1'b0;
                r.w  = 4'd0;
            end
            drive(r);
            #1;
            n_cmp++;
            if (out_en !== '0) begin
                n_err++;
                $display("FAIL reset_en c%0d: out_en=%b, need 0000", c, out_en);
            end
            n_cmp++;
            if (full !== 1'b0) begin
                n_err++;
                $display("FAIL reset_full c%0d: full=%b, need 0", c, full);
            end
            tick();
        end
    endtask

    task automatic test_basic();
        row_t t [5];
        logic [FW-1:0] em;
        t = '{'{4'd8, 5'd3, 1'b0, 1'b0, 1'b0}, '{4'd0, 5'd0, 1'b0, 1'b0, 1'b0},
              '{4'd0, 5'd0, 1'b0, 1'b1, 1'b0}, '{4'd0, 5'd0, 1'b0, 1'b0, 1'b0},
              '{4'd0, 5'd0, 1'b0, 1'b0, 1'b0}};
        for (int c = 0; c < 5; c++) begin
            drive(t[c]);
            #1;
            em = model_en();
            n_cmp++;
            if (out_en !== em || full !== model_full()) begin
                n_err++;
                $display("FAIL basic_ctl c%0d: out_en=%b full=%b, need %b %b", c, out_en, full, em, model_full());
            end
            for (int i = 0; i < FW; i++)
                if (em[i]) begin
                    n_cmp++;
                    if (out_inst[i] !== m_inst[i] || out_fsqIdx[i] !== m_fsq[i]) begin
                        n_err++;
                        $display("FAIL basic_data c%0d s%0d: got %h/%0d, need %h/%0d", c, i, out_inst[i], out_fsqIdx[i], m_inst[i], m_fsq[i]);
                    end
                end
            if (c == 1) begin
                n_cmp++;
                if (out_fsqIdx !== {FW{5'd3}}) begin
                    n_err++;
                    $display("FAIL basic_fsq: out_fsqIdx=%h, need all 3", out_fsqIdx);
                end
            end
            tick();
        end
    endtask

    task automatic test_fill();
        row_t t [9];
        logic [FW-1:0] em;
        t = '{'{4'd8, 5'd1, 1'b0, 1'b1, 1'b0}, '{4'd5, 5'd2, 1'b0, 1'b1, 1'b0},
              '{4'd8, 5'd3, 1'b0, 1'b1, 1'b0}, '{4'd0, 5'd0, 1'b0, 1'b1, 1'b0},
              '{4'd0, 5'd0, 1'b0, 1'b0, 1'b0}, '{4'd0, 5'd0, 1'b0, 1'b0, 1'b0},
              '{4'd0, 5'd0, 1'b0, 1'b0, 1'b0}, '{4'd0, 5'd0, 1'b0, 1'b0, 1'b0},
              '{4'd0, 5'd0, 1'b0, 1'b0, 1'b0}};
        for (int c = 0; c < 9; c++) begin
            drive(t[c]);
            #1;
            em = model_en();
            n_cmp++;
            if (out_en !== em || full !== model_full()) begin
                n_err++;
                $display("FAIL fill_ctl c%0d: out_en=%b full=%b, need %b %b", c, out_en, full, em, model_full());
            end
            for (int i = 0; i < FW; i++)
                if (em[i]) begin
                    n_cmp++;
                    if (out_inst[i] !== m_inst[i] || out_fsqIdx[i] !== m_fsq[i]) begin
                        n_err++;
                        $display("FAIL fill_data c%0d s%0d: got %h/%0d, need %h/%0d", c, i, out_inst[i], out_fsqIdx[i], m_inst[i], m_fsq[i]);
                    end
                end
            tick();
        end
    endtask

    task automatic test_wrap();
        row_t t [11];
        logic [FW-1:0] em;
        t = '{'{4'd0, 5'd0, 1'b1, 1'b0, 1'b0}, '{4'd8, 5'd4, 1'b0, 1'b1, 1'b0},
              '{4'd6, 5'd5, 1'b0, 1'b1, 1'b0}, '{4'd0, 5'd0, 1'b0, 1'b0, 1'b0},
              '{4'd0, 5'd0, 1'b0, 1'b0, 1'b0}, '{4'd0, 5'd0, 1'b0, 1'b0, 1'b0},
              '{4'd0, 5'd0, 1'b0, 1'b0, 1'b0}, '{4'd4, 5'd6, 1'b0, 1'b1, 1'b0},
              '{4'd0, 5'd0, 1'b0, 1'b1, 1'b0}, '{4'd0, 5'd0, 1'b0, 1'b0, 1'b0},
              '{4'd0, 5'd0, 1'b0, 1'b0, 1'b0}};
        for (int c = 0; c < 11; c++) begin
            drive(t[c]);
            #1;
            em = model_en();
            n_cmp++;
            if (out_en !== em || full !== model_full()) begin
                n_err++;
                $display("FAIL wrap_ctl c%0d: out_en=%b full=%b, need %b %b", c, out_en, full, em, model_full());
            end
            for (int i = 0; i < FW; i++)
                if (em[i]) begin
                    n_cmp++;
                    if (out_inst[i] !== m_inst[i] || out_fsqIdx[i] !== m_fsq[i]) begin
                        n_err++;
                        $display("FAIL wrap_data c%0d s%0d: got %h/%0d, need %h/%0d", c, i, out_inst[i], out_fsqIdx[i], m_inst[i], m_fsq[i]);
                    end
                end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        row_t t [6];
        logic [FW-1:0] em;
        t = '{'{4'd0, 5'd0, 1'b1, 1'b0, 1'b0}, '{4'd6, 5'd7, 1'b0, 1'b1, 1'b0},
              '{4'd3, 5'd8, 1'b0, 1'b0, 1'b0}, '{4'd0, 5'd0, 1'b0, 1'b1, 1'b0},
              '{4'd0, 5'd0, 1'b0, 1'b0, 1'b0}, '{4'd0, 5'd0, 1'b0, 1'b0, 1'b0}};
        for (int c = 0; c < 6; c++) begin
            drive(t[c]);
            #1;
            em = model_en();
            n_cmp++;
            if (out_en !== em || full !== model_full()) begin
                n_err++;
                $display("FAIL simul_ctl c%0d: out_en=%b full=%b, need %b %b", c, out_en, full, em, model_full());
            end
            for (int i = 0; i < FW; i++)
                if (em[i]) begin
                    n_cmp++;
                    if (out_inst[i] !== m_inst[i] || out_fsqIdx[i] !== m_fsq[i]) begin
                        n_err++;
                        $display("FAIL simul_data c%0d s%0d: got %h/%0d, need %h/%0d", c, i, out_inst[i], out_fsqIdx[i], m_inst[i], m_fsq[i]);
                    end
                end
            tick();
        end
    endtask

    task automatic test_flush();
        row_t t [6];
        logic [FW-1:0] em;
        t = '{'{4'd8, 5'd9,  1'b0, 1'b1, 1'b0}, '{4'd2, 5'd10, 1'b0, 1'b1, 1'b0},
              '{4'd8, 5'd11, 1'b1, 1'b0, 1'b0}, '{4'd0, 5'd0,  1'b0, 1'b1, 1'b0},
              '{4'd4, 5'd12, 1'b0, 1'b0, 1'b0}, '{4'd0, 5'd0,  1'b0, 1'b0, 1'b0}};
        for (int c = 0; c < 6; c++) begin
            drive(t[c]);
            #1;
            em = model_en();
            n_cmp++;
            if (out_en !== em || full !== model_full()) begin
                n_err++;
                $display("FAIL flush_ctl c%0d: out_en=%b full=%b, need %b %b", c, out_en, full, em, model_full());
            end
            for (int i = 0; i < FW; i++)
                if (em[i]) begin
                    n_cmp++;
                    if (out_inst[i] !== m_inst[i] || out_fsqIdx[i] !== m_fsq[i]) begin
                        n_err++;
                        $display("FAIL flush_data c%0d s%0d: got %h/%0d, need %h/%0d", c, i, out_inst[i], out_fsqIdx[i], m_inst[i], m_fsq[i]);
                    end
                end
            tick();
        end
    endtask

    task automatic test_rst_mid();
        row_t t [7];
        logic [FW-1:0] em;
        t = '{'{4'd8, 5'd13, 1'b0, 1'b1, 1'b0}, '{4'd8, 5'd14, 1'b0, 1'b0, 1'b1},
              '{4'd0, 5'd0,  1'b0, 1'b1, 1'b0}, '{4'd3, 5'd15, 1'b0, 1'b1, 1'b0},
              '{4'd8, 5'd16, 1'b1, 1'b1, 1'b1}, '{4'd0, 5'd0,  1'b0, 1'b0, 1'b0},
              '{4'd2, 5'd17, 1'b0, 1'b0, 1'b0}};
        for (int c = 0; c < 7; c++) begin
            drive(t[c]);
            #1;
            em = model_en();
            n_cmp++;
            if (out_en !== em || full !== model_full()) begin
                n_err++;
                $display("FAIL rstmid_ctl c%0d: out_en=%b full=%b, need %b %b", c, out_en, full, em, model_full());
            end
            for (int i = 0; i < FW; i++)
                if (em[i]) begin
                    n_cmp++;
                    if (out_inst[i] !== m_inst[i] || out_fsqIdx[i] !== m_fsq[i]) begin
                        n_err++;
                        $display("FAIL rstmid_data c%0d s%0d: got %h/%0d, need %h/%0d", c, i, out_inst[i], out_fsqIdx[i], m_inst[i], m_fsq[i]);
                    end
                end
            tick();
        end
    endtask

    task automatic test_random();
        row_t r;
        logic [FW-1:0] em;
        for (int c = 0; c < 400; c++) begin
            r.rs = ($urandom_range(0, 49) == 0);
            r.fl = ($urandom_range(0, 19) == 0);
            r.st = ($urandom_range(0, 2) == 0);
            r.w  = model_full() ? 4'd0 : 4'($urandom_range(0, 8));
            r.f  = FSQ_W'($urandom);
            drive(r);
            #1;
            em = model_en();
            n_cmp++;
            if (out_en !== em || full !== model_full()) begin
                n_err++;
                $display("FAIL rand_ctl c%0d: out_en=%b full=%b, need %b %b", c, out_en, full, em, model_full());
            end
            for (int i = 0; i < FW; i++)
                if (em[i]) begin
                    n_cmp++;
                    if (out_inst[i] !== m_inst[i] || out_fsqIdx[i] !== m_fsq[i]) begin
                        n_err++;
                        $display("FAIL rand_data c%0d s%0d: got %h/%0d, need %h/%0d", c, i, out_inst[i], out_fsqIdx[i], m_inst[i], m_fsq[i]);
                    end
                end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_wrap();
        test_simultaneous();
        test_flush();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
